// File: rtl/mipi_frame_receiver.sv
// MIPI packet-stream frame receiver: SOF detect, ID/header capture, payload assembly
// into one OUT_W-bit frame with valid/ready output, length check and inter-word timeout.
module mipi_frame_receiver #(
  parameter int          PKT_W       = 48,
  parameter int          OUT_W       = 512,
  parameter int          MAX_WORDS   = 11,
  parameter logic [15:0] SOF_MARK    = 16'hEAFF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic             rx_pixel_clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] packet,
  input  logic             packet_valid,
  output logic [OUT_W-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [31:0]      pkt_id,
  output logic [7:0]       dtype,
  output logic [7:0]       phl_id,
  output logic [31:0]      frame_len,
  output logic             busy,
  output logic             err_len,
  output logic             err_timeout,
  output logic             err_drop
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ID, S_HDR, S_PAYLOAD} state_t;

  state_t           r_state, w_next;
  logic [OUT_W-1:0] r_shreg, w_shifted;
  logic [31:0]      r_k, r_dlen, r_pkt_id, w_hdr_dlen;
  logic [7:0]       r_dtype, r_phl;
  logic [TW-1:0]    r_tmo;
  logic             w_tmo, w_len_bad, w_done;

  logic [OUT_W-1:0] r_data;
  logic [31:0]      r_out_id, r_out_len;
  logic [7:0]       r_out_dtype, r_out_phl;
  logic             r_data_valid, r_err_len, r_err_timeout, r_err_drop;

  assign w_hdr_dlen = packet[39:8];
  assign w_len_bad  = (w_hdr_dlen == 32'd0) || (w_hdr_dlen > 32'(MAX_WORDS));
  assign w_shifted  = (r_shreg << PKT_W) | OUT_W'(packet);
  assign w_done     = (r_state == S_PAYLOAD) && packet_valid && (r_k == r_dlen - 32'd1);
  assign w_tmo      = (r_state != S_IDLE) && !packet_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (packet_valid && packet[15:0] == SOF_MARK) w_next = S_ID;
      S_ID:      if (packet_valid) w_next = S_HDR;
                 else if (w_tmo) w_next = S_IDLE;
      S_HDR:     if (packet_valid) w_next = w_len_bad ? S_IDLE : S_PAYLOAD;
                 else if (w_tmo) w_next = S_IDLE;
      S_PAYLOAD: if (w_done) w_next = S_IDLE;
                 else if (w_tmo) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Capture path: header fields, payload shift register, word and idle counters
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      r_shreg  <= '0;
      r_k      <= '0;
      r_dlen   <= '0;
      r_pkt_id <= '0;
      r_dtype  <= '0;
      r_phl    <= '0;
      r_tmo    <= '0;
    end else begin
      if (r_state == S_IDLE || packet_valid || w_tmo) r_tmo <= '0;
      else                                             r_tmo <= r_tmo + TW'(1);
      if (packet_valid) begin
        case (r_state)
          S_ID: r_pkt_id <= packet[47:16];
          S_HDR: begin
            r_dtype <= packet[7:0];
            r_dlen  <= w_hdr_dlen;
            r_phl   <= packet[47:40];
            r_shreg <= '0;
            r_k     <= '0;
          end
          S_PAYLOAD: begin
            r_shreg <= w_shifted;
            r_k     <= r_k + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output register: a completing frame loads only when the slot is free or being emptied
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      r_data        <= '0;
      r_out_id      <= '0;
      r_out_len     <= '0;
      r_out_dtype   <= '0;
      r_out_phl     <= '0;
      r_data_valid  <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      r_err_len     <= (r_state == S_HDR) && packet_valid && w_len_bad;
      r_err_timeout <= w_tmo;
      r_err_drop    <= w_done && r_data_valid && !data_ready;
      if (w_done && (!r_data_valid || data_ready)) begin
        r_data       <= w_shifted;
        r_out_id     <= r_pkt_id;
        r_out_len    <= r_dlen;
        r_out_dtype  <= r_dtype;
        r_out_phl    <= r_phl;
        r_data_valid <= 1'b1;
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign pkt_id      = r_out_id;
  assign dtype       = r_out_dtype;
  assign phl_id      = r_out_phl;
  assign frame_len   = r_out_len;
  assign busy        = (r_state != S_IDLE);
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign err_drop    = r_err_drop;

endmodule

// File: doc/mipi_frame_receiver.md
Name: mipi_frame_receiver

Overview:
Parametrised successor to the first-generation MIPI packet receiver. It consumes the packet word stream on the rx_pixel_clk domain and detects the start-of-frame marker. It then captures the packet-ID word and the header word (dtype/dlen/phl_id), and assembles dlen payload words into one OUT_W-bit frame. Over the earlier receiver it adds: input qualifier, length check, inter-word timeout, a valid/ready output handshake with drop detection, and a clean reset. It sits between the MIPI RX pixel interface and the miner work-loading logic.

Parameters:
PKT_W, 48, packet word width; must be >=48 because header fields occupy bits [47:0].
OUT_W, 512, assembled frame width.
MAX_WORDS, 11, largest legal dlen; default is ceil(OUT_W/PKT_W).
SOF_MARK, 16'hEAFF, start-of-frame marker compared against packet[15:0].
TIMEOUT_CYC, 1024, idle cycles allowed between accepted words inside a frame; must be >=1.

Ports:
rx_pixel_clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
packet  in  PKT_W  incoming packet word
packet_valid  in  1  packet word is valid this cycle
data  out  OUT_W  assembled frame
data_valid  out  1  frame available, held until accepted
data_ready  in  1  consumer accepts frame
pkt_id  out  32  packet ID of the frame on data
dtype  out  8  data type of the frame on data
phl_id  out  8  PHL ID of the frame on data
frame_len  out  32  dlen of the frame on data
busy  out  1  high in any state other than IDLE
err_len  out  1  one-cycle pulse: illegal dlen
err_timeout  out  1  one-cycle pulse: frame aborted on timeout
err_drop  out  1  one-cycle pulse: completed frame discarded because the output register was occupied

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; shift register, word counter and timeout counter cleared. Reset asserted mid-frame discards the partial frame; no error pulse is issued.
- States and transitions. Only words with packet_valid=1 are acted on; words with packet_valid=0 are ignored.
  - IDLE: packet[15:0]==SOF_MARK -> ID. Other words are ignored.
  - ID: pkt_id_r <= packet[47:16] -> HDR.
  - HDR: dtype_r <= packet[7:0]; dlen_r <= packet[39:8]; phl_r <= packet[47:40].
    - If dlen==0 or dlen>MAX_WORDS: err_len=1 for one cycle -> IDLE.
    - Otherwise: shift register <= 0, word counter k <= 0 -> PAYLOAD.
  - PAYLOAD: each word does shreg <= (shreg << PKT_W) | packet, truncated to OUT_W, and k <= k+1. The word where k==dlen_r-1 completes the frame -> IDLE. A SOF_MARK pattern inside the payload is treated as data.
- Frame output:
  - Last word sits in data[PKT_W-1:0]; earlier words occupy higher slices.
  - Slots above dlen*PKT_W are zero.
  - When dlen*PKT_W > OUT_W, the most-significant bits of the oldest word are truncated. At the defaults with dlen=11, the top 16 bits of word 0 are lost.
- Latency: data_valid rises on the first clock edge after the cycle in which the last payload word is sampled. On that same edge, data, pkt_id, dtype, phl_id and frame_len load together.
- Handshake:
  - Transfer occurs when data_valid && data_ready.
  - All output fields stay stable while data_valid=1 and no transfer has occurred.
  - data_valid clears after a transfer unless a new frame completes in that same cycle. In that case the new frame loads and data_valid stays 1.
  - If a frame completes while data_valid=1 and data_ready=0: the new frame is discarded, err_drop pulses, and the held frame is untouched.
  - The input side never stalls, because the MIPI stream cannot be back-pressured.
- Timeout:
  - In ID, HDR and PAYLOAD, a counter increments on every cycle with packet_valid=0 and resets to 0 on every accepted word.
  - When the counter reaches TIMEOUT_CYC: err_timeout pulses, state -> IDLE, partial data is discarded. The counter is held at 0 in IDLE.
- Error pulses are mutually exclusive within a frame and last exactly one cycle.
- busy=1 in ID, HDR and PAYLOAD.

Test Plan:
1. Nominal: send SOF 48'h0000_0000_EAFF, ID 48'h1234_5678_0000, HDR 48'h07_00000002_2A, then payload 48'hAAAA_AAAA_AAAA and 48'h0000_0000_0001, with data_ready=1 -> one cycle after word 2, data_valid=1 with data={416'b0, 48'hAAAA_AAAA_AAAA, 48'h1}, pkt_id=32'h12345678, dtype=8'h2A, phl_id=8'h07, frame_len=2.
2. Length error: header carrying dlen=0, then a second frame with dlen=12 -> err_len pulses once per frame, data_valid never asserts, busy returns to 0.
3. Backpressure/drop: hold data_ready=0 and send two complete frames -> the first frame is held stable, err_drop pulses at completion of the second, and the first frame is delivered once data_ready=1.
4. Timeout: after 3 of 5 payload words, hold packet_valid=0 for 1024 cycles -> err_timeout pulses on cycle 1024 and the state is IDLE. A following good frame is received correctly.
5. Gaps and embedded SOF: insert packet_valid=0 gaps shorter than TIMEOUT_CYC, plus a payload word 48'h0000_0000_EAFF -> the frame assembles with 48'hEAFF in the correct slot.
6. Async reset asserted mid-PAYLOAD -> all outputs are 0 immediately, and the next frame assembles correctly.
